// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: control-word layout and bubble constant.
package cpu_pkg;

    localparam int CTRL_W = 10;

    // {RegWr,MemRd,MemWr,MemtoReg,ALUSrc,RegDst,ALUOp[3:0]}
    localparam int CTRL_REGWR    = 9;
    localparam int CTRL_MEMRD    = 8;
    localparam int CTRL_MEMWR    = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_REGDST   = 4;
    localparam int CTRL_ALUOP    = 0;
    localparam int ALUOP_W       = 4;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection between the load in EX and the reader in ID.
module load_use_detect (
    input  logic       rst_n_i,
    input  logic       flush_i,
    input  logic       ex_valid_i,
    input  logic       ex_memrd_i,
    input  logic [4:0] ex_rt_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    output logic       ld_use_o,
    output logic       stall_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (ex_rt_i == id_rs_i);
    assign rt_hit = id_uses_rt_i & (ex_rt_i == id_rt_i);

    assign ld_use_o = ex_valid_i & ex_memrd_i & (ex_rt_i != 5'd0)
                    & (rs_hit | rt_hit) & id_valid_i;

    // A taken branch kills the reader, so there is nothing to wait for.
    assign stall_o = ld_use_o & ~flush_i & rst_n_i;

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion and WB bypass.
module id_ex_hazard_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = cpu_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_reg_wr,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_wr_addr,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  ld_stall_cnt
);

    import cpu_pkg::*;

    logic              valid_q, valid_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        wr_q, wr_d;
    logic [DATA_W-1:0] rsd_q, rsd_d;
    logic [DATA_W-1:0] rtd_q, rtd_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ld_use;
    logic              wb_ok;
    logic [CTRL_W-1:0] id_ctrl_eff;

    load_use_detect u_lud (
        .rst_n_i      (rst_n),
        .flush_i      (flush),
        .ex_valid_i   (valid_q),
        .ex_memrd_i   (ctrl_q[CTRL_MEMRD]),
        .ex_rt_i      (rt_q),
        .id_valid_i   (id_valid),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_uses_rt_i (id_uses_rt),
        .ld_use_o     (ld_use),
        .stall_o      (stall)
    );

    assign wb_ok       = wb_reg_wr & (wb_addr != 5'd0);
    assign id_ctrl_eff = id_valid ? id_ctrl : CTRL_NOP;

    always_comb begin
        valid_d = 1'b0;
        rs_d    = '0;
        rt_d    = '0;
        wr_d    = '0;
        rsd_d   = '0;
        rtd_d   = '0;
        imm_d   = '0;
        ctrl_d  = CTRL_NOP;
        if (!(flush | ld_use)) begin
            valid_d = id_valid;
            rs_d    = id_rs;
            rt_d    = id_rt;
            imm_d   = id_imm;
            ctrl_d  = id_ctrl_eff;
            rsd_d   = (wb_ok && wb_addr == id_rs) ? wb_data : id_rs_data;
            rtd_d   = (wb_ok && wb_addr == id_rt) ? wb_data : id_rt_data;
            // Non-writers get address 0 so forwarding never matches them.
            if (id_ctrl_eff[CTRL_REGWR])
                wr_d = id_ctrl_eff[CTRL_REGDST] ? id_rd : id_rt;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rs_q    <= '0;
            rt_q    <= '0;
            wr_q    <= '0;
            rsd_q   <= '0;
            rtd_q   <= '0;
            imm_q   <= '0;
            ctrl_q  <= CTRL_NOP;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            wr_q    <= wr_d;
            rsd_q   <= rsd_d;
            rtd_q   <= rtd_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_wr_addr   = wr_q;
    assign ex_rs_data   = rsd_q;
    assign ex_rt_data   = rtd_q;
    assign ex_imm       = imm_q;
    assign ex_ctrl      = ctrl_q;
    assign ld_stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg with a 4-bit stall counter.
module tb_id_ex_hazard_reg;

    localparam int DW = 32;
    localparam int CW = 10;
    localparam int NW = 4;

    localparam logic [CW-1:0] C_LW  = 10'h360;
    localparam logic [CW-1:0] C_ADD = 10'h212;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          id_uses_rt;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [CW-1:0] id_ctrl;
    logic          wb_reg_wr;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          stall;
    logic          ex_valid;
    logic [4:0]    ex_rs, ex_rt, ex_wr_addr;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [CW-1:0] ex_ctrl;
    logic [NW-1:0] ld_stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_hazard_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_reg_wr(wb_reg_wr), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wr_addr(ex_wr_addr),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ld_stall_cnt(ld_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic ur, input logic [31:0] a,
                          input logic [31:0] b, input logic [CW-1:0] c);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_uses_rt = ur;
        id_rs_data = a;
        id_rt_data = b;
        id_imm     = 32'h4;
        id_ctrl    = c;
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        wb_reg_wr  = 1'b0;
        wb_addr    = 5'd0;
        wb_data    = '0;
        set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1,
               $urandom, $urandom, C_LW);
        tick();
        tick();
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_ctrl", 32'(ex_ctrl), 0);
        chk("rst_rs_data", ex_rs_data, 0);
        chk("rst_wr", 32'(ex_wr_addr), 0);
        chk("rst_cnt", 32'(ld_stall_cnt), 0);
        chk("rst_stall", 32'(stall), 0);

        // lw $8 then add reading $8
        rst_n = 1'b1;
        set_id(1'b1, 5'd2, 5'd8, 5'd0, 1'b0, 32'd100, 32'd200, C_LW);
        tick();
        chk("lw_valid", 32'(ex_valid), 1);
        chk("lw_wr", 32'(ex_wr_addr), 8);
        chk("lw_ctrl", 32'(ex_ctrl), 32'(C_LW));
        set_id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 32'd1, 32'd2, C_ADD);
        chk("lu_stall", 32'(stall), 1);
        tick();
        chk("bub_valid", 32'(ex_valid), 0);
        chk("bub_ctrl", 32'(ex_ctrl), 0);
        chk("bub_rs", 32'(ex_rs), 0);
        chk("bub_cnt", 32'(ld_stall_cnt), 1);
        chk("bub_stall", 32'(stall), 0);
        tick();
        chk("add_valid", 32'(ex_valid), 1);
        chk("add_rs", 32'(ex_rs), 8);
        chk("add_wr", 32'(ex_wr_addr), 10);
        chk("add_ctrl", 32'(ex_ctrl), 32'(C_ADD));
        chk("add_cnt", 32'(ld_stall_cnt), 1);

        // loads to $0 and rt-not-read are not hazards
        set_id(1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 0, 0, C_LW);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 0, 0, C_ADD);
        chk("r0_stall", 32'(stall), 0);
        set_id(1'b1, 5'd2, 5'd8, 5'd0, 1'b0, 0, 0, C_LW);
        tick();
        set_id(1'b1, 5'd3, 5'd8, 5'd4, 1'b0, 0, 0, C_ADD);
        chk("nort_stall", 32'(stall), 0);

        // flush beats load-use
        set_id(1'b1, 5'd8, 5'd1, 5'd4, 1'b1, 0, 0, C_ADD);
        chk("pre_flush_stall", 32'(stall), 1);
        flush = 1'b1;
        #1;
        chk("flush_stall", 32'(stall), 0);
        tick();
        flush = 1'b0;
        chk("flush_valid", 32'(ex_valid), 0);
        chk("flush_cnt", 32'(ld_stall_cnt), 1);

        // WB write-through to both operands
        wb_reg_wr = 1'b1;
        wb_addr   = 5'd5;
        wb_data   = 32'hDEADBEEF;
        set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 0, 0, C_ADD);
        tick();
        chk("byp_rs", ex_rs_data, 32'hDEADBEEF);
        chk("byp_rt", ex_rt_data, 32'hDEADBEEF);
        chk("byp_wr", 32'(ex_wr_addr), 6);
        wb_addr = 5'd0;
        wb_data = 32'h1234;
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 32'h11, 32'h22, C_ADD);
        tick();
        chk("byp0_rs", ex_rs_data, 32'h11);
        chk("byp0_rt", ex_rt_data, 32'h22);
        wb_reg_wr = 1'b0;

        // invalid ID instruction drops its control
        set_id(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 0, 0, C_ADD);
        tick();
        chk("inv_valid", 32'(ex_valid), 0);
        chk("inv_ctrl", 32'(ex_ctrl), 0);
        chk("inv_wr", 32'(ex_wr_addr), 0);

        // reset while stalling
        set_id(1'b1, 5'd2, 5'd8, 5'd0, 1'b0, 0, 0, C_LW);
        tick();
        set_id(1'b1, 5'd8, 5'd1, 5'd4, 1'b0, 0, 0, C_ADD);
        chk("pre_rst_stall", 32'(stall), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(stall), 0);
        tick();
        chk("rst_mid_valid", 32'(ex_valid), 0);
        chk("rst_mid_cnt", 32'(ld_stall_cnt), 0);
        rst_n = 1'b1;

        // self-dependent loads stall every other cycle
        set_id(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 0, 0, C_LW);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("sat_stall", 32'(stall), 1);
            tick();
            chk("sat_cnt", 32'(ld_stall_cnt), (i + 1 > 15) ? 15 : i + 1);
            tick();
        end
        chk("sat_final", 32'(ld_stall_cnt), 15);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
